// File: rtl/jk_bank_sched.sv
`default_nettype none
// ============================================================================
//  Module   : jk_bank_sched
//  Purpose  : Command scheduler for a bank of WIDTH JK flip-flops. Two
//             requesters (A, B) issue per-bit hold/clear/set/toggle commands
//             over valid/ready handshakes. The winner is registered onto the
//             J/K drive vectors and a shadow copy of the bank state (q) is
//             kept. Toggle commands with a nonzero count expand into a
//             multi-cycle toggle burst.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             a_valid/a_ready/a_op/a_mask/a_cnt - requester A command channel
//             b_valid/b_ready/b_op/b_mask/b_cnt - requester B command channel
//             j, k                  - registered J/K drive to the bank
//             q                     - shadow bank state
//             busy                  - high while a toggle burst is running
//             grant_b               - last accepted requester (0 = A, 1 = B)
//  Config   : JK_SCHED_RR_EN defined   -> round-robin arbitration
//             JK_SCHED_RR_EN undefined -> fixed priority, A wins
//  Revision : 1.0 - initial release
// ============================================================================
module jk_bank_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [1:0]       a_op,
    input  logic [WIDTH-1:0] a_mask,
    input  logic [CNT_W-1:0] a_cnt,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_mask,
    input  logic [CNT_W-1:0] b_cnt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             grant_b
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_burst = 1'b1;
    localparam logic [1:0] c_op_tog   = 2'b11;

    logic [0:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_mask, w_mask_nxt;
    logic [WIDTH-1:0] r_j, r_k, r_q;
    logic [WIDTH-1:0] w_j_nxt, w_k_nxt, w_q_nxt;
    logic             r_grant_b, w_grant_b_nxt;

    logic             w_idle;
    logic             w_sel_b;
    logic             w_xfer;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_mask;
    logic [CNT_W-1:0] w_cnt;

    // Readies are gated by rst so nothing is handed over on a reset edge.
    assign w_idle = (r_state == c_st_idle) & ~rst;

`ifdef JK_SCHED_RR_EN
    // Pointer names the requester that wins a tie; after every transfer it
    // moves to the requester that was not just served.
    logic r_ptr_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_b <= 1'b0;
        end else if (w_xfer) begin
            r_ptr_b <= ~w_sel_b;
        end
    end

    assign w_sel_b = b_valid & (~a_valid | r_ptr_b);
`else
    assign w_sel_b = b_valid & ~a_valid;
`endif

    assign a_ready = w_idle & a_valid & ~w_sel_b;
    assign b_ready = w_idle & w_sel_b;
    assign w_xfer  = a_ready | b_ready;

    assign w_op   = w_sel_b ? b_op   : a_op;
    assign w_mask = w_sel_b ? b_mask : a_mask;
    assign w_cnt  = w_sel_b ? b_cnt  : a_cnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_rem;
        w_mask_nxt    = r_mask;
        w_grant_b_nxt = r_grant_b;
        w_j_nxt       = '0;
        w_k_nxt       = '0;
        case (r_state)
            c_st_idle: begin
                if (w_xfer) begin
                    // op[1] selects J (set/toggle), op[0] selects K (clear/toggle)
                    w_j_nxt       = w_mask & {WIDTH{w_op[1]}};
                    w_k_nxt       = w_mask & {WIDTH{w_op[0]}};
                    w_grant_b_nxt = w_sel_b;
                    if ((w_op == c_op_tog) && (w_cnt != '0)) begin
                        w_state_nxt = c_st_burst;
                        w_rem_nxt   = w_cnt;
                        w_mask_nxt  = w_mask;
                    end
                end
            end
            c_st_burst: begin
                w_j_nxt   = r_mask;
                w_k_nxt   = r_mask;
                w_rem_nxt = r_rem - CNT_W'(1);
                if (r_rem == CNT_W'(1)) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // JK next-state applied to the shadow copy with the values being driven.
    assign w_q_nxt = (r_q & ~w_k_nxt) | (~r_q & w_j_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_rem     <= '0;
            r_mask    <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_q       <= '0;
            r_grant_b <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rem     <= w_rem_nxt;
            r_mask    <= w_mask_nxt;
            r_j       <= w_j_nxt;
            r_k       <= w_k_nxt;
            r_q       <= w_q_nxt;
            r_grant_b <= w_grant_b_nxt;
        end
    end

    assign j       = r_j;
    assign k       = r_k;
    assign q       = r_q;
    assign busy    = (r_state == c_st_burst);
    assign grant_b = r_grant_b;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_bank_sched
//  Purpose  : Self-checking bench for jk_bank_sched (WIDTH 8, CNT_W 4):
//             directed scenarios plus randomized traffic against a
//             behavioural model that tracks q and remaining burst pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_ready, b_ready;
    logic [1:0] a_op = 2'b00, b_op = 2'b00;
    logic [7:0] a_mask = 8'h00, b_mask = 8'h00;
    logic [3:0] a_cnt = 4'h0, b_cnt = 4'h0;
    logic [7:0] j, k, q;
    logic       busy, grant_b;

    int checks = 0;
    int errors = 0;

    // model state
    int         m_left = 0;
    logic [7:0] m_mask = 8'h00;
    logic [7:0] m_q = 8'h00;
    logic       m_ptr_b = 1'b0;
    logic [7:0] exp_j = 8'h00, exp_k = 8'h00, exp_q = 8'h00;
    logic       exp_busy = 1'b0, exp_grant = 1'b0, exp_ar = 1'b0, exp_br = 1'b0;
    logic       obs_ar, obs_br;

    jk_bank_sched #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_mask(a_mask), .a_cnt(a_cnt),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_mask(b_mask), .b_cnt(b_cnt),
        .j(j), .k(k), .q(q), .busy(busy), .grant_b(grant_b)
    );

    always #5 clk = ~clk;

    // One clock: sample readies, advance across the edge, update the model.
    task automatic step();
        logic       wb;
        logic [1:0] op;
        logic [7:0] mk;
        logic [3:0] ct;
        #1;
        obs_ar = a_ready;
        obs_br = b_ready;
        if (rst || m_left > 0) begin
            exp_ar = 1'b0;
            exp_br = 1'b0;
        end else begin
`ifdef JK_SCHED_RR_EN
            wb = b_valid && (!a_valid || m_ptr_b);
`else
            wb = b_valid && !a_valid;
`endif
            exp_ar = a_valid && !wb;
            exp_br = wb;
        end
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_q = 8'h00; m_ptr_b = 1'b0;
            exp_j = 8'h00; exp_k = 8'h00; exp_grant = 1'b0;
        end else if (m_left > 0) begin
            exp_j = m_mask; exp_k = m_mask;
            m_q = m_q ^ m_mask;
            m_left = m_left - 1;
        end else if (exp_ar || exp_br) begin
            op = exp_br ? b_op : a_op;
            mk = exp_br ? b_mask : a_mask;
            ct = exp_br ? b_cnt : a_cnt;
            exp_j = 8'h00; exp_k = 8'h00;
            case (op)
                2'd1: begin exp_k = mk; m_q = m_q & ~mk; end
                2'd2: begin exp_j = mk; m_q = m_q | mk; end
                2'd3: begin
                    exp_j = mk; exp_k = mk; m_q = m_q ^ mk;
                    if (ct != 0) begin m_left = ct; m_mask = mk; end
                end
                default: ;
            endcase
            exp_grant = exp_br;
            m_ptr_b = !exp_br;
        end else begin
            exp_j = 8'h00; exp_k = 8'h00;
        end
        exp_q = m_q;
        exp_busy = (m_left > 0);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic set_a(input logic v, input logic [1:0] op, input logic [7:0] mk, input logic [3:0] ct);
        a_valid = v; a_op = op; a_mask = mk; a_cnt = ct;
    endtask

    task automatic set_b(input logic v, input logic [1:0] op, input logic [7:0] mk, input logic [3:0] ct);
        b_valid = v; b_op = op; b_mask = mk; b_cnt = ct;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_a(1'b1, 2'b10, 8'hFF, 4'h0);
        step();
        checks++; if (obs_ar !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b exp 0", obs_ar); end
        checks++; if ({j, k, q} !== 24'h0) begin errors++; $display("FAIL reset_jkq got %h exp 000000", {j, k, q}); end
        checks++; if ({busy, grant_b} !== 2'b00) begin errors++; $display("FAIL reset_busy_grant got %b exp 00", {busy, grant_b}); end
        rst = 1'b0;
        set_a(1'b1, 2'b00, 8'h00, 4'h0);
        step();
        checks++; if (obs_ar !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b exp 1", obs_ar); end
        a_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_a(1'b1, 2'b10, 8'h0F, 4'h0);
        step();
        checks++; if ({j, k, q} !== 24'h0F000F) begin errors++; $display("FAIL single_set got jkq %h exp 0f000f", {j, k, q}); end
        set_a(1'b0, 2'b00, 8'h00, 4'h0);
        set_b(1'b1, 2'b01, 8'h03, 4'h0);
        step();
        checks++; if ({j, k, q} !== 24'h00030C) begin errors++; $display("FAIL single_clear got jkq %h exp 00030c", {j, k, q}); end
        checks++; if (grant_b !== 1'b1) begin errors++; $display("FAIL single_grant_b got %b exp 1", grant_b); end
        b_valid = 1'b0;
        set_a(1'b1, 2'b00, 8'hFF, 4'h0);
        step();
        checks++; if ({j, k, q} !== 24'h00000C) begin errors++; $display("FAIL single_hold got jkq %h exp 00000c", {j, k, q}); end
        checks++; if (grant_b !== 1'b0) begin errors++; $display("FAIL single_hold_grant got %b exp 0", grant_b); end
        a_valid = 1'b0;
    endtask

    task automatic test_burst();
        logic [7:0] qseq [4] = '{8'h01, 8'h00, 8'h01, 8'h00};
        logic       bseq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        set_a(1'b1, 2'b11, 8'h01, 4'd3);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) set_a(1'b1, 2'b00, 8'h00, 4'h0);  // hold pending during burst
            checks++;
            if (obs_ar !== (i == 0)) begin errors++; $display("FAIL burst_ready[%0d] got %b exp %b", i, obs_ar, (i == 0)); end
            checks++;
            if ({j, k, q, busy} !== {8'h01, 8'h01, qseq[i], bseq[i]})
                begin errors++; $display("FAIL burst_pulse[%0d] got j %h k %h q %h busy %b exp 01 01 %h %b", i, j, k, q, busy, qseq[i], bseq[i]); end
        end
        step();
        checks++; if (obs_ar !== 1'b1) begin errors++; $display("FAIL burst_ready_after got %b exp 1", obs_ar); end
        checks++; if ({j, k, q} !== 24'h0) begin errors++; $display("FAIL burst_after_jkq got %h exp 000000", {j, k, q}); end
        a_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic g;
        do_reset();
        set_a(1'b1, 2'b10, 8'h01, 4'h0);
        set_b(1'b1, 2'b10, 8'h02, 4'h0);
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef JK_SCHED_RR_EN
            g = i[0];
`else
            g = 1'b0;
`endif
            checks++; if (grant_b !== g) begin errors++; $display("FAIL contention_grant[%0d] got %b exp %b", i, grant_b, g); end
        end
        a_valid = 1'b0;
        step();
        checks++; if (grant_b !== 1'b1) begin errors++; $display("FAIL contention_b_after got %b exp 1", grant_b); end
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL contention_q got %h exp 03", q); end
        b_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_a(1'b1, 2'b11, 8'h05, 4'd10);
        step();
        a_valid = 1'b0;
        step(); step();
        checks++; if ({q, busy} !== {8'h05, 1'b1}) begin errors++; $display("FAIL midrst_pre got q %h busy %b exp 05 1", q, busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({j, k, q, busy} !== 25'h0) begin errors++; $display("FAIL midrst_clear got j %h k %h q %h busy %b exp 0", j, k, q, busy); end
        set_a(1'b1, 2'b10, 8'h01, 4'h0);
        step();
        checks++; if ({obs_ar, q} !== {1'b1, 8'h01}) begin errors++; $display("FAIL midrst_idle got ready %b q %h exp 1 01", obs_ar, q); end
        a_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [3] = '{2'b10, 2'b01, 2'b11};
        logic [7:0] mks [3] = '{8'hFF, 8'hF0, 8'h0F};
        logic [7:0] qs  [3] = '{8'hFF, 8'h0F, 8'h00};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, ops[i], mks[i], 4'h0);
            step();
            checks++;
            if ({obs_ar, q} !== {1'b1, qs[i]}) begin errors++; $display("FAIL b2b[%0d] got ready %b q %h exp 1 %h", i, obs_ar, q, qs[i]); end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_random();
        logic a_acc = 1'b1, b_acc = 1'b1;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (!a_valid || a_acc)
                set_a($urandom_range(0, 9) < 7, 2'($urandom), 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            if (!b_valid || b_acc)
                set_b($urandom_range(0, 9) < 7, 2'($urandom), 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            rst = ($urandom_range(0, 63) == 0);
            step();
            a_acc = obs_ar && a_valid;
            b_acc = obs_br && b_valid;
            checks++;
            if ({obs_ar, obs_br} !== {exp_ar, exp_br})
                begin errors++; $display("FAIL rand_ready[%0d] got %b%b exp %b%b", i, obs_ar, obs_br, exp_ar, exp_br); end
            checks++;
            if ({j, k, q, busy, grant_b} !== {exp_j, exp_k, exp_q, exp_busy, exp_grant})
                begin errors++; $display("FAIL rand_out[%0d] got j %h k %h q %h busy %b g %b exp %h %h %h %b %b",
                                         i, j, k, q, busy, grant_b, exp_j, exp_k, exp_q, exp_busy, exp_grant); end
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_contention();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
